m_wb_uart: RTL and testbench

//  Wishbone classic slave UART (8N1, fixed baud) on the midgetv core bus of the upduino2 target.

---
 rtl/m_wb_uart.sv | 267 ++++++++++++++++++++++++++
 tb/tb_m_wb_uart.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_wb_uart.sv
// m_wb_uart: Wishbone classic slave UART, 8N1 at a fixed CLK_I/DIVISOR bit rate.
// A TX holding register feeds a shifter; the RX side keeps one byte plus overrun/framing flags.
module m_wb_uart #(
  parameter int unsigned DIVISOR = 208,
  parameter int unsigned DIVW    = 16
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       CYC_I,
  input  logic       STB_I,
  input  logic       WE_I,
  input  logic       ADR_I,
  input  logic [7:0] DAT_I,
  output logic [7:0] DAT_O,
  output logic       ACK_O,
  input  logic       usartRX,
  output logic       usartTX,
  output logic       irq
);

  localparam logic [DIVW-1:0] RELOAD = DIVW'(DIVISOR - 32'd1);
  localparam logic [DIVW-1:0] HALF   = DIVW'(DIVISOR / 32'd2);
  localparam logic [DIVW-1:0] ONE    = DIVW'(32'd1);
  localparam logic [DIVW-1:0] ZERO   = DIVW'(32'd0);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic            ack_r;
  logic [7:0]      dat_r;

  tx_state_t       tx_state_r;
  logic [7:0]      tx_hold_r;
  logic [7:0]      tx_shift_r;
  logic            tx_full_r;
  logic            tx_busy_r;
  logic [DIVW-1:0] tx_cnt_r;
  logic [2:0]      tx_bit_r;
  logic            tx_line_r;

  logic            rx_meta_r;
  logic            rx_sync_r;
  logic            rx_prev_r;
  rx_state_t       rx_state_r;
  logic [DIVW-1:0] rx_cnt_r;
  logic [2:0]      rx_bit_r;
  logic [7:0]      rx_shift_r;
  logic [7:0]      rx_byte_r;
  logic            rx_valid_r;
  logic            ovr_r;
  logic            ferr_r;

  logic access_s;
  logic wr_data_s;
  logic wr_stat_s;
  logic rd_data_s;
  logic tx_tick_s;
  logic tx_load_s;
  logic rx_tick_s;
  logic rx_fall_s;
  logic rx_good_s;
  logic rx_bad_s;

  assign access_s  = CYC_I & STB_I & ~ack_r;
  assign wr_data_s = access_s & WE_I & ~ADR_I;
  assign wr_stat_s = access_s & WE_I & ADR_I;
  assign rd_data_s = access_s & ~WE_I & ~ADR_I;

  // The shifter takes the holding byte when idle or at the end of a stop bit (no idle gap).
  assign tx_tick_s = (tx_cnt_r == ZERO);
  assign tx_load_s = tx_full_r & ((tx_state_r == TX_IDLE) | ((tx_state_r == TX_STOP) & tx_tick_s));

  assign rx_tick_s = (rx_cnt_r == ZERO);
  assign rx_fall_s = rx_prev_r & ~rx_sync_r;
  assign rx_good_s = (rx_state_r == RX_STOP) & rx_tick_s & rx_sync_r;
  assign rx_bad_s  = (rx_state_r == RX_STOP) & rx_tick_s & ~rx_sync_r;

  assign ACK_O   = ack_r;
  assign DAT_O   = dat_r;
  assign usartTX = tx_line_r;
  assign irq     = rx_valid_r | (~tx_full_r & ~tx_busy_r);

  // Bus response: one-cycle ACK pulse, read data captured at the access edge.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ack_r <= 1'b0;
      dat_r <= 8'h00;
    end else begin
      ack_r <= access_s;
      if (access_s && !WE_I) begin
        if (ADR_I) begin
          dat_r <= {4'b0000, ferr_r, ovr_r, rx_valid_r, tx_full_r | tx_busy_r};
        end else begin
          dat_r <= rx_byte_r;
        end
      end
    end
  end

  // Transmit path: holding register plus start/data/stop shifter FSM.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      tx_state_r <= TX_IDLE;
      tx_hold_r  <= 8'h00;
      tx_shift_r <= 8'h00;
      tx_full_r  <= 1'b0;
      tx_busy_r  <= 1'b0;
      tx_cnt_r   <= ZERO;
      tx_bit_r   <= 3'd0;
      tx_line_r  <= 1'b1;
    end else begin
      if (wr_data_s && !tx_full_r) begin
        tx_hold_r <= DAT_I;
        tx_full_r <= 1'b1;
      end
      if (tx_load_s) begin
        tx_shift_r <= tx_hold_r;
        tx_full_r  <= 1'b0;
        tx_busy_r  <= 1'b1;
        tx_line_r  <= 1'b0;
        tx_cnt_r   <= RELOAD;
        tx_state_r <= TX_START;
      end else begin
        case (tx_state_r)
          TX_IDLE: begin
            tx_busy_r <= 1'b0;
            tx_line_r <= 1'b1;
          end
          TX_START: begin
            if (tx_tick_s) begin
              tx_cnt_r   <= RELOAD;
              tx_bit_r   <= 3'd0;
              tx_line_r  <= tx_shift_r[0];
              tx_state_r <= TX_DATA;
            end else begin
              tx_cnt_r <= tx_cnt_r - ONE;
            end
          end
          TX_DATA: begin
            if (tx_tick_s) begin
              tx_cnt_r <= RELOAD;
              if (tx_bit_r == 3'd7) begin
                tx_line_r  <= 1'b1;
                tx_state_r <= TX_STOP;
              end else begin
                tx_bit_r   <= tx_bit_r + 3'd1;
                tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                tx_line_r  <= tx_shift_r[1];
              end
            end else begin
              tx_cnt_r <= tx_cnt_r - ONE;
            end
          end
          TX_STOP: begin
            if (tx_tick_s) begin
              tx_busy_r  <= 1'b0;
              tx_state_r <= TX_IDLE;
            end else begin
              tx_cnt_r <= tx_cnt_r - ONE;
            end
          end
          default: begin
            tx_busy_r  <= 1'b0;
            tx_line_r  <= 1'b1;
            tx_state_r <= TX_IDLE;
          end
        endcase
      end
    end
  end

  // Two-stage synchroniser plus a delayed copy for falling-edge start detection.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= usartRX;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receive FSM: start bit is re-checked half a bit in, so short low glitches fall back to idle.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= ZERO;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
    end else begin
      case (rx_state_r)
        RX_IDLE: begin
          if (rx_fall_s) begin
            rx_cnt_r   <= HALF;
            rx_state_r <= RX_START;
          end
        end
        RX_START: begin
          if (rx_tick_s) begin
            rx_cnt_r   <= RELOAD;
            rx_bit_r   <= 3'd0;
            rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r - ONE;
          end
        end
        RX_DATA: begin
          if (rx_tick_s) begin
            rx_cnt_r   <= RELOAD;
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            if (rx_bit_r == 3'd7) begin
              rx_state_r <= RX_STOP;
            end else begin
              rx_bit_r <= rx_bit_r + 3'd1;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r - ONE;
          end
        end
        RX_STOP: begin
          if (rx_tick_s) begin
            rx_state_r <= RX_IDLE;
          end else begin
            rx_cnt_r <= rx_cnt_r - ONE;
          end
        end
        default: begin
          rx_state_r <= RX_IDLE;
        end
      endcase
    end
  end

  // RX buffer and flags; a byte landing on the same edge as a DATA read replaces the one being read.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_byte_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      ovr_r      <= 1'b0;
      ferr_r     <= 1'b0;
    end else begin
      if (wr_stat_s && DAT_I[2]) begin
        ovr_r <= 1'b0;
      end
      if (wr_stat_s && DAT_I[3]) begin
        ferr_r <= 1'b0;
      end
      if (rd_data_s) begin
        rx_valid_r <= 1'b0;
      end
      if (rx_good_s) begin
        if (rx_valid_r && !rd_data_s) begin
          ovr_r <= 1'b1;
        end else begin
          rx_byte_r  <= rx_shift_r;
          rx_valid_r <= 1'b1;
        end
      end
      if (rx_bad_s) begin
        ferr_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_m_wb_uart.sv
// Self-checking bench for m_wb_uart: register table, directed TX/RX corner cases,
// then random traffic scored against a frame-level model of the RX buffer and flags.
module tb_m_wb_uart;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cyc_i = 1'b0;
  logic       stb = 1'b0;
  logic       we = 1'b0;
  logic       adr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       ack;
  logic       rx = 1'b1;
  logic       tx;
  logic       irq;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;

  logic [7:0]  tx_q[$];
  logic        tx_ok_q[$];
  int unsigned tx_st_q[$];

  typedef struct {
    logic       we;
    logic       adr;
    logic [7:0] din;
    logic [7:0] exp_dat;
    logic       exp_irq;
  } vec_t;
  vec_t vecs[5];

  // model of the RX buffer, advanced once per complete frame or bus access
  logic [7:0] m_rxbyte;
  logic       m_rxvalid;
  logic       m_ovr;
  logic       m_ferr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  m_wb_uart #(.DIVISOR(DIV), .DIVW(16)) dut (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc_i), .STB_I(stb), .WE_I(we), .ADR_I(adr),
    .DAT_I(din), .DAT_O(dout), .ACK_O(ack), .usartRX(rx), .usartTX(tx), .irq(irq)
  );

  // Line monitor: decode each TX frame at mid-bit and record its first start-bit cycle.
  initial begin : tx_mon
    logic [7:0]  b;
    logic        ok;
    int unsigned st;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        st = cyc;
        ok = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
        tx_q.push_back(b);
        tx_ok_q.push_back(ok);
        tx_st_q.push_back(st);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus(input logic w, input logic a, input logic [7:0] d, output logic [7:0] q);
    @(negedge clk);
    cyc_i = 1'b1; stb = 1'b1; we = w; adr = a; din = d;
    @(posedge clk);
    #1;
    check("ack", 32'(ack), 32'd1);
    q = dout;
    @(negedge clk);
    cyc_i = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    logic [7:0] q;
    bus(1'b1, a, d, q);
  endtask

  task automatic rd_chk(input logic a, input logic [7:0] e, input string name);
    logic [7:0] q;
    bus(1'b0, a, 8'h00, q);
    check(name, 32'(q), 32'(e));
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = f[i];
      repeat (DIV - 1) @(negedge clk);
    end
    @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_tx_log();
    tx_q.delete();
    tx_ok_q.delete();
    tx_st_q.delete();
  endtask

  task automatic wait_tx(input int n);
    int k;
    k = 0;
    while (tx_q.size() < n && k < 40 * DIV) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] d;
    int         op;

    vecs[0] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", 32'(dout), 32'd0);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].we) wr(vecs[i].adr, vecs[i].din);
      else rd_chk(vecs[i].adr, vecs[i].exp_dat, "vec_read");
      check("vec_irq", 32'(irq), 32'(vecs[i].exp_irq));
    end

    // STB held for two edges must produce a single ACK
    @(negedge clk);
    cyc_i = 1'b1; stb = 1'b1; we = 1'b0; adr = 1'b1;
    @(posedge clk); #1;
    check("hold_ack1", 32'(ack), 32'd1);
    @(posedge clk); #1;
    check("hold_ack2", 32'(ack), 32'd0);
    @(negedge clk);
    cyc_i = 1'b0; stb = 1'b0;

    // single frame 0xA5
    clear_tx_log();
    wr(1'b0, 8'hA5);
    repeat (20) @(negedge clk);
    rd_chk(1'b1, 8'h01, "tx_busy_stat");
    check("tx_busy_irq", 32'(irq), 32'd0);
    wait_tx(1);
    check("a5_frames", 32'(tx_q.size()), 32'd1);
    check("a5_byte", 32'(tx_q.size() > 0 ? tx_q[0] : 8'h00), 32'hA5);
    check("a5_ok", 32'(tx_ok_q.size() > 0 ? tx_ok_q[0] : 1'b0), 32'd1);
    repeat (12) @(negedge clk);
    rd_chk(1'b1, 8'h00, "tx_done_stat");
    check("tx_done_irq", 32'(irq), 32'd1);

    // back-to-back frames, third write dropped while the holding register is full
    clear_tx_log();
    wr(1'b0, 8'h55);
    wr(1'b0, 8'h0F);
    wr(1'b0, 8'hF0);
    repeat (40 * DIV) @(negedge clk);
    check("b2b_frames", 32'(tx_q.size()), 32'd2);
    check("b2b_byte0", 32'(tx_q.size() > 0 ? tx_q[0] : 8'h00), 32'h55);
    check("b2b_byte1", 32'(tx_q.size() > 1 ? tx_q[1] : 8'h00), 32'h0F);
    check("b2b_ok", 32'(tx_ok_q.size() > 1 ? (tx_ok_q[0] & tx_ok_q[1]) : 1'b0), 32'd1);
    check("b2b_gap", tx_st_q.size() > 1 ? (tx_st_q[1] - tx_st_q[0]) : 32'd0, 32'(10 * DIV));

    // RX 0x3C while TX is busy, so irq tracks rxvalid alone
    clear_tx_log();
    wr(1'b0, 8'h81);
    wr(1'b0, 8'h42);
    send_rx(8'h3C, 1'b1);
    rd_chk(1'b1, 8'h03, "rx_stat_busy");
    check("rx_irq_set", 32'(irq), 32'd1);
    rd_chk(1'b0, 8'h3C, "rx_data");
    check("rx_irq_clr", 32'(irq), 32'd0);
    rd_chk(1'b1, 8'h01, "rx_stat_read");
    repeat (20 * DIV) @(negedge clk);
    rd_chk(1'b1, 8'h00, "rx_stat_idle");
    check("rx_tx_bytes", 32'(tx_q.size() > 1 ? {tx_q[0], tx_q[1]} : 16'h0000), 32'h8142);

    // overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd_chk(1'b1, 8'h06, "ovr_stat");
    rd_chk(1'b0, 8'h11, "ovr_data");
    rd_chk(1'b1, 8'h04, "ovr_stat2");
    wr(1'b1, 8'h04);
    rd_chk(1'b1, 8'h00, "ovr_clr");

    // framing error
    send_rx(8'h77, 1'b0);
    rd_chk(1'b1, 8'h08, "ferr_stat");
    wr(1'b1, 8'h08);
    rd_chk(1'b1, 8'h00, "ferr_clr");

    // two-cycle low glitch
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    rd_chk(1'b1, 8'h00, "glitch_stat");

    // random traffic against the frame-level model
    m_rxbyte = 8'h11; m_rxvalid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 5));
      b  = 8'($urandom);
      case (op)
        0: begin
          clear_tx_log();
          wr(1'b0, b);
          wait_tx(1);
          check("rnd_tx_cnt", 32'(tx_q.size()), 32'd1);
          check("rnd_tx_byte", 32'(tx_q.size() > 0 ? tx_q[0] : ~b), 32'(b));
          repeat (12) @(negedge clk);
        end
        1: begin
          send_rx(b, 1'b1);
          if (m_rxvalid) m_ovr = 1'b1;
          else begin m_rxbyte = b; m_rxvalid = 1'b1; end
        end
        2: begin
          send_rx(b, 1'b0);
          m_ferr = 1'b1;
        end
        3: begin
          rd_chk(1'b0, m_rxbyte, "rnd_data");
          m_rxvalid = 1'b0;
        end
        4: rd_chk(1'b1, {4'b0000, m_ferr, m_ovr, m_rxvalid, 1'b0}, "rnd_stat");
        default: begin
          d = 8'($urandom);
          wr(1'b1, d);
          if (d[2]) m_ovr = 1'b0;
          if (d[3]) m_ferr = 1'b0;
        end
      endcase
    end
    rd_chk(1'b1, {4'b0000, m_ferr, m_ovr, m_rxvalid, 1'b0}, "rnd_final_stat");

    // asynchronous reset in the middle of a frame
    send_rx(8'h99, 1'b1);
    wr(1'b0, 8'h00);
    repeat (30) @(negedge clk);
    check("tx_low_mid", 32'(tx), 32'd0);
    #2 rst = 1'b1;
    #1 check("tx_async_rst", 32'(tx), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rd_chk(1'b1, 8'h00, "post_rst_stat");
    repeat (12 * DIV) @(negedge clk);
    check("post_rst_tx", 32'(tx), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
